// File: rtl/axis_wr_data_pkg.sv
// Shared types and helper constants for the AXI-stream to AXI4 write-data engine.
package axis_wr_data_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int DEF_CONVERT_SHIFT = 1;
    localparam int DEF_AXI_LEN_WIDTH = 4;
    localparam int DEF_MAX_BURST     = 1 << DEF_AXI_LEN_WIDTH;

    // Stream words packed into one AXI beat.
    function automatic int ratio(input int shift);
        return 1 << shift;
    endfunction

    function automatic int max_burst(input int len_width);
        return 1 << len_width;
    endfunction

endpackage

// File: rtl/axis_wr_data_fifo.sv
// Synchronous beat FIFO with registered storage, count, full and empty flags.
module axis_wr_data_fifo #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   count
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [AWIDTH:0]   count_nxt;
    logic              do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AWIDTH+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/axis_wr_data.sv
// Packs stream words into AXI beats and drives the W channel with burst wlast.
// Define AXIS_WR_DATA_ASSERT_EN to compile in simulation-only protocol checks.
module axis_wr_data
    import axis_wr_data_pkg::*;
#(
    parameter int BUF_AWIDTH     = 4,
    parameter int CFG_DWIDTH     = 32,
    parameter int CONVERT_SHIFT  = DEF_CONVERT_SHIFT,
    parameter int AXI_LEN_WIDTH  = DEF_AXI_LEN_WIDTH,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_val,
    output logic                      cfg_rdy,
    output logic                      axi_wlast,
    output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      valid,
    output logic                      ready
);
    localparam int RATIO = ratio(CONVERT_SHIFT);
    localparam int MAXB  = max_burst(AXI_LEN_WIDTH);

    state_t                    state;
    logic [CFG_DWIDTH-1:0]     words, beats, word_cnt, beat_cnt, lane;
    logic [AXI_LEN_WIDTH-1:0]  burst_cnt;
    logic [AXI_DATA_WIDTH-1:0] pack, pack_nxt;
    logic                      fifo_full, fifo_empty;
    logic [BUF_AWIDTH:0]       fifo_count;
    logic                      accept, push, pop, last_word, final_beat;

    assign lane       = word_cnt & CFG_DWIDTH'(RATIO - 1);
    assign pack_nxt   = pack | (AXI_DATA_WIDTH'(data) << (lane * DATA_WIDTH));
    assign ready      = (state == ACTIVE) && (word_cnt != words) && !fifo_full;
    assign accept     = valid && ready;
    assign last_word  = (word_cnt == words - 1'b1);
    assign push       = accept && ((lane == CFG_DWIDTH'(RATIO - 1)) || last_word);
    assign axi_wvalid = !fifo_empty;
    assign pop        = axi_wvalid && axi_wready;
    assign final_beat = (beat_cnt == beats - 1'b1);
    assign axi_wlast  = axi_wvalid &&
                        ((burst_cnt == AXI_LEN_WIDTH'(MAXB - 1)) || final_beat);

    axis_wr_data_fifo #(
        .AWIDTH (BUF_AWIDTH),
        .DWIDTH (AXI_DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (pack_nxt),
        .pop   (pop),
        .dout  (axi_wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_rdy   <= 1'b1;
            words     <= '0;
            beats     <= '0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            pack      <= '0;
        end else begin
            if (pop) begin
                beat_cnt  <= beat_cnt + 1'b1;
                burst_cnt <= axi_wlast ? '0 : burst_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cfg_val && cfg_rdy && cfg_length != '0) begin
                        words     <= cfg_length;
                        beats     <= (cfg_length + CFG_DWIDTH'(RATIO - 1)) >> CONVERT_SHIFT;
                        word_cnt  <= '0;
                        beat_cnt  <= '0;
                        burst_cnt <= '0;
                        pack      <= '0;
                        cfg_rdy   <= 1'b0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        word_cnt <= word_cnt + 1'b1;
                        pack     <= push ? '0 : pack_nxt;
                        if (last_word)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Everything is already in the FIFO, so the final beat is its last entry.
                    if (pop && fifo_count == (BUF_AWIDTH+1)'(1)) begin
                        cfg_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cfg_rdy <= 1'b1;
                end
            endcase
        end
    end

`ifdef AXIS_WR_DATA_ASSERT_EN
    logic prev_stall;
    always @(posedge clk) begin
        if (!rst) begin
            if (push && fifo_full)
                $error("axis_wr_data: FIFO overflow");
            if (pop && fifo_empty)
                $error("axis_wr_data: FIFO underflow");
            if (prev_stall && !axi_wvalid)
                $error("axis_wr_data: axi_wvalid dropped without handshake");
            if (cfg_val && cfg_rdy && state != IDLE)
                $error("axis_wr_data: cfg accepted while not idle");
        end
        prev_stall <= !rst && axi_wvalid && !axi_wready;
    end
`else
    // Checks compiled out; datapath and control are unchanged.
`endif

endmodule

// File: tb/tb_axis_wr_data.sv
// Randomized directed bench for axis_wr_data with a word-list reference model.
module tb_axis_wr_data;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_length;
    logic        cfg_val;
    logic        cfg_rdy;
    logic        axi_wlast;
    logic [63:0] axi_wdata;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wbuf [4200];
    logic [63:0] exp_d [$];
    logic        exp_l [$];
    bit          in_xfer = 1'b0;
    bit          chk_idle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic        prev_l;

    axis_wr_data dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_length (cfg_length),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .axi_wlast  (axi_wlast),
        .axi_wdata  (axi_wdata),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready),
        .data       (data),
        .valid      (valid),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: beat b holds words 2b (low half) and 2b+1 (high half, zero past the end).
    function automatic void build_exp(input int len);
        int nb;
        logic [31:0] hi;
        nb = (len + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            hi = (2*b + 1 < len) ? wbuf[2*b + 1] : 32'h0;
            exp_d.push_back({hi, wbuf[2*b]});
            exp_l.push_back((b % 16 == 15) || (b == nb - 1));
        end
    endfunction

    function automatic logic wr_sel(input int mode, input int idx, input int cyc);
        case (mode)
            1:       return (idx < 5) ? 1'b1 : (idx < 8) ? 1'b0 : logic'(cyc % 2);
            2:       return $urandom_range(3) != 0;
            3:       return $urandom_range(3) == 0;
            4:       return cyc >= 60;
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_idle) begin
            check("cfg_rdy_after_last", cfg_rdy, 1);
            chk_idle = 1'b0;
        end
        if (!rst && prev_stall) begin
            check("hold_valid", axi_wvalid, 1);
            check("hold_data", axi_wdata, prev_d);
            check("hold_last", axi_wlast, prev_l);
        end
        if (!rst && axi_wvalid && axi_wready) begin
            check("beat_expected", exp_d.size() != 0, 1);
            if (exp_d.size() != 0) begin
                check("wdata", axi_wdata, exp_d.pop_front());
                check("wlast", axi_wlast, exp_l.pop_front());
                if (exp_d.size() == 0 && in_xfer)
                    chk_idle = 1'b1;
            end
        end
        prev_stall = !rst && axi_wvalid && !axi_wready;
        prev_d     = axi_wdata;
        prev_l     = axi_wlast;
    end

    task automatic do_cfg(input int len);
        @(posedge clk); #1;
        cfg_length = len;
        cfg_val    = 1'b1;
        @(negedge clk);
        check("cfg_rdy_idle", cfg_rdy, 1);
        @(posedge clk); #1;
        cfg_val = 1'b0;
        @(negedge clk);
        check("cfg_rdy_after_cfg", cfg_rdy, len == 0);
        check("ready_after_cfg", ready, len != 0);
    endtask

    task automatic feed(input int len, input int gap, input int wmode,
                        input int stop_at, inout int idx, inout int cyc);
        int since;
        since = gap;
        while (idx < stop_at && cyc < 20000) begin
            @(posedge clk); #1;
            valid      = (since >= gap);
            data       = wbuf[idx];
            axi_wready = wr_sel(wmode, idx, cyc);
            @(negedge clk);
            if (wmode == 4 && cyc == 60)
                check("fifo_full_stall", idx, 32);
            if (valid && ready) begin
                idx++;
                since = 0;
            end else begin
                since++;
            end
            cyc++;
        end
        check("words_accepted", idx, stop_at);
        if (len == 0) check("zero_len_idx", idx, 0);
    endtask

    task automatic xfer(input int len, input int gap, input int wmode, input bit seq);
        int idx, cyc, extra;
        idx = 0; cyc = 0; extra = 0;
        for (int i = 0; i < len; i++)
            wbuf[i] = seq ? 32'(i + 1) : $urandom;
        build_exp(len);
        in_xfer = 1'b1;
        do_cfg(len);
        feed(len, gap, wmode, len, idx, cyc);
        // Keep offering a word past the end; it must never be taken.
        while (!(exp_d.size() == 0 && cfg_rdy) && cyc < 20000) begin
            @(posedge clk); #1;
            valid      = 1'b1;
            data       = 32'hdead_beef;
            axi_wready = wr_sel(wmode, idx, cyc);
            @(negedge clk);
            if (valid && ready) extra++;
            cyc++;
        end
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check("drain_done", (exp_d.size() == 0) && cfg_rdy, 1);
        check("extra_refused", extra, 0);
        exp_d.delete();
        exp_l.delete();
        in_xfer = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_rdy"}, cfg_rdy, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_wvalid"}, axi_wvalid, 0);
        check({tag, "_wlast"}, axi_wlast, 0);
        check({tag, "_wdata"}, axi_wdata, 64'h0);
    endtask

    initial begin
        int idx, cyc;
        rst = 1'b1; cfg_length = '0; cfg_val = 1'b0;
        axi_wready = 1'b0; data = '0; valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        xfer(8, 0, 0, 1'b1);       // words 1..8, wready held high
        xfer(8, 0, 1, 1'b1);       // stall after 5 words, then toggling wready
        xfer(8, 5, 0, 1'b1);       // sparse words
        xfer(4092, 0, 0, 1'b1);    // 2046 beats, short final burst
        xfer(3, 0, 0, 1'b0);       // partial final beat
        xfer(40, 0, 4, 1'b0);      // FIFO fills while wready is low
        xfer(0, 0, 0, 1'b0);       // zero length stays idle
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("zero_len_no_beat", axi_wvalid, 0);
        for (int t = 0; t < 6; t++)
            xfer($urandom_range(1, 40), $urandom_range(0, 2), 2 + (t % 2), 1'b0);

        // Abort after 5 of 8 words, then a clean transfer.
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        build_exp(8);
        in_xfer = 1'b1;
        do_cfg(8);
        idx = 0; cyc = 0;
        feed(8, 0, 0, 5, idx, cyc);
        @(posedge clk); #1;
        valid = 1'b0; axi_wready = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("abort");
        exp_d.delete();
        exp_l.delete();
        in_xfer = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(8, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
